// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, bidirectional shift/rotate, parallel load and clear.
// A saturating shift counter with a one-cycle done pulse marks a completed word.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             si_l,
  input  logic             si_r,
  output logic [WIDTH-1:0] q,
  output logic             so_r,
  output logic             so_l,
  output logic [CW-1:0]    cnt,
  output logic             done
);

  typedef enum logic [2:0] {
    OpHold  = 3'b000,
    OpShr   = 3'b001,
    OpShl   = 3'b010,
    OpRor   = 3'b011,
    OpRol   = 3'b100,
    OpLoad  = 3'b101,
    OpClear = 3'b110,
    OpRsvd  = 3'b111
  } op_e;

  localparam logic [CW-1:0] CntFull = CW'(WIDTH);
  localparam logic [CW-1:0] CntLast = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             so_r_q, so_r_d;
  logic             so_l_q, so_l_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;

  op_e              op;
  logic             is_shift;
  logic [WIDTH-1:0] shr_val, shl_val, ror_val, rol_val;
  logic [CW-1:0]    cnt_inc;
  logic             cnt_wrap;

  assign op = op_e'(mode);

  assign shr_val = {si_l, q_q[WIDTH-1:1]};
  assign shl_val = {q_q[WIDTH-2:0], si_r};
  assign ror_val = {q_q[0], q_q[WIDTH-1:1]};
  assign rol_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]};

  assign is_shift = (op == OpShr) || (op == OpShl) || (op == OpRor) || (op == OpRol);

  // Saturating count; done fires only on the step that fills the word.
  assign cnt_inc  = (cnt_q < CntFull) ? cnt_q + CW'(1) : cnt_q;
  assign cnt_wrap = (cnt_q == CntLast);

  always_comb begin
    q_d    = q_q;
    so_r_d = so_r_q;
    so_l_d = so_l_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;

    if (en) begin
      unique case (op)
        OpShr: begin
          q_d    = shr_val;
          so_r_d = q_q[0];
        end
        OpShl: begin
          q_d    = shl_val;
          so_l_d = q_q[WIDTH-1];
        end
        OpRor: begin
          q_d    = ror_val;
          so_r_d = q_q[0];
        end
        OpRol: begin
          q_d    = rol_val;
          so_l_d = q_q[WIDTH-1];
        end
        OpLoad: begin
          q_d   = din;
          cnt_d = '0;
        end
        OpClear: begin
          q_d    = '0;
          so_r_d = 1'b0;
          so_l_d = 1'b0;
          cnt_d  = '0;
        end
        OpHold, OpRsvd: begin
        end
        default: begin
        end
      endcase

      if (is_shift) begin
        cnt_d  = cnt_inc;
        done_d = cnt_wrap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      q_q    <= '0;
      so_r_q <= 1'b0;
      so_l_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      so_r_q <= so_r_d;
      so_l_q <= so_l_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = q_q;
  assign so_r = so_r_q;
  assign so_l = so_l_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg: a reference model pushes expected state per edge
// to a scoreboard queue, popped and compared after the edge; plus literal checks.
module tb_univ_shift_reg;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         en;
  logic [2:0]   mode;
  logic [W-1:0] din;
  logic         si_l;
  logic         si_r;
  logic [W-1:0] q;
  logic         so_r;
  logic         so_l;
  logic [3:0]   cnt;
  logic         done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         so_r;
    logic         so_l;
    logic [3:0]   cnt;
    logic         done;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [W-1:0] m_q    = '0;
  logic         m_sor  = 1'b0;
  logic         m_sol  = 1'b0;
  logic [3:0]   m_cnt  = '0;
  logic         m_done = 1'b0;

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .mode (mode),
    .din  (din),
    .si_l (si_l),
    .si_r (si_r),
    .q    (q),
    .so_r (so_r),
    .so_l (so_l),
    .cnt  (cnt),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic [2:0] m,
                       input logic [W-1:0] d, input logic sl, input logic sr);
    logic shifted;
    shifted = 1'b0;
    if (!r) begin
      m_q = '0; m_sor = 1'b0; m_sol = 1'b0; m_cnt = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (e) begin
        case (m)
          3'b001: begin m_sor = m_q[0];   m_q = {sl, m_q[W-1:1]};     shifted = 1'b1; end
          3'b010: begin m_sol = m_q[W-1]; m_q = {m_q[W-2:0], sr};     shifted = 1'b1; end
          3'b011: begin m_sor = m_q[0];   m_q = {m_q[0], m_q[W-1:1]}; shifted = 1'b1; end
          3'b100: begin m_sol = m_q[W-1]; m_q = {m_q[W-2:0], m_q[W-1]}; shifted = 1'b1; end
          3'b101: begin m_q = d; m_cnt = '0; end
          3'b110: begin m_q = '0; m_sor = 1'b0; m_sol = 1'b0; m_cnt = '0; end
          default: ;
        endcase
        if (shifted && m_cnt != 4'(W)) begin
          m_cnt = m_cnt + 4'd1;
          if (m_cnt == 4'(W)) m_done = 1'b1;
        end
      end
    end
  endtask

  // Drive one edge, push the model's prediction, then pop and compare after the edge.
  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [W-1:0] d, input logic sl, input logic sr);
    exp_t x;
    @(negedge clk);
    rstn = r; en = e; mode = m; din = d; si_l = sl; si_r = sr;
    model(r, e, m, d, sl, sr);
    sb.push_back('{q: m_q, so_r: m_sor, so_l: m_sol, cnt: m_cnt, done: m_done});
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("sb_q",    q,            x.q);
    chk("sb_so_r", W'(so_r),     W'(x.so_r));
    chk("sb_so_l", W'(so_l),     W'(x.so_l));
    chk("sb_cnt",  W'(cnt),      W'(x.cnt));
    chk("sb_done", W'(done),     W'(x.done));
  endtask

  localparam logic [2:0] HOLD = 3'b000, SHR = 3'b001, SHL = 3'b010, ROR = 3'b011;
  localparam logic [2:0] ROL = 3'b100, LOAD = 3'b101, CLR = 3'b110, RSVD = 3'b111;

  initial begin
    logic [7:0] ser_bits;
    logic [7:0] des_bits;
    int         done_seen;
    ser_bits = 8'b1010_0101;  // expected so_r order, LSB first
    des_bits = 8'b1101_0010;  // fed MSB first on si_r
    rstn = 1'b0; en = 1'b0; mode = HOLD; din = '0; si_l = 1'b0; si_r = 1'b0;

    // Reset overrides en/mode
    step(1'b0, 1'b0, HOLD, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, LOAD, 8'h6B, 1'b0, 1'b0);
    chk("load_6b", q, 8'h6B);
    step(1'b0, 1'b1, SHR, 8'h00, 1'b1, 1'b1);
    chk("rst_q", q, 8'h00);
    chk("rst_cnt", W'(cnt), 8'd0);

    // Serialise 0xA5 out of the LSB end
    step(1'b1, 1'b1, LOAD, 8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, SHR, 8'h00, 1'b0, 1'b0);
      chk("ser_so_r", W'(so_r), W'(ser_bits[i]));
      chk("ser_done", W'(done), (i == 7) ? 8'd1 : 8'd0);
    end
    chk("ser_q", q, 8'h00);
    chk("ser_cnt", W'(cnt), 8'd8);
    step(1'b1, 1'b1, HOLD, 8'h00, 1'b0, 1'b0);
    chk("ser_done_fall", W'(done), 8'd0);

    // Deserialise into the LSB end
    step(1'b1, 1'b1, CLR, 8'h00, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, 1'b1, SHL, 8'h00, 1'b0, des_bits[i]);
      chk("des_so_l", W'(so_l), 8'd0);
    end
    chk("des_q", q, 8'hD2);
    chk("des_cnt", W'(cnt), 8'd8);

    // Rotate left past saturation
    step(1'b1, 1'b1, LOAD, 8'h81, 1'b0, 1'b0);
    done_seen = 0;
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b1, ROL, 8'h00, 1'b0, 1'b0);
      if (done === 1'b1) done_seen++;
      if (i == 1) chk("rol_1", q, 8'h03);
      if (i == 8) chk("rol_8", q, 8'h81);
    end
    chk("rol_10", q, 8'h06);
    chk("rol_cnt_sat", W'(cnt), 8'd8);
    chk("rol_done_once", W'(done_seen), 8'd1);

    // Enable gating freezes state mid-word
    step(1'b1, 1'b1, LOAD, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, SHR, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, SHR, 8'h00, 1'b1, 1'b1);
    chk("en_q_held", q, 8'h07);
    chk("en_cnt_held", W'(cnt), 8'd3);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, SHR, 8'h00, 1'b0, 1'b0);
    chk("en_done", W'(done), 8'd1);
    chk("en_cnt", W'(cnt), 8'd8);
    step(1'b1, 1'b0, SHR, 8'h00, 1'b0, 1'b0);
    chk("en0_done_fall", W'(done), 8'd0);

    // Reserved mode, LOAD while saturated, CLEAR
    step(1'b1, 1'b1, LOAD, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 1'b1, RSVD, 8'hFF, 1'b1, 1'b1);
    chk("rsvd_hold", q, 8'h5A);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
    chk("ror_back", q, 8'h5A);
    chk("ror_so_r", W'(so_r), 8'd0);
    step(1'b1, 1'b1, LOAD, 8'hF1, 1'b0, 1'b0);
    chk("load_sat_cnt", W'(cnt), 8'd0);
    chk("load_so_r_held", W'(so_r), 8'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, ROR, 8'h00, 1'b0, 1'b0);
    chk("new_word_done", W'(done), 8'd1);
    chk("new_word_so_r", W'(so_r), 8'd1);
    step(1'b1, 1'b1, CLR, 8'h00, 1'b0, 1'b0);
    chk("clr_so", W'({so_l, so_r}), 8'd0);

    // Reset mid-word abandons the count
    step(1'b1, 1'b1, LOAD, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, SHL, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, SHL, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, SHL, 8'h00, 1'b0, 1'b1);
    chk("partial_done", W'(done), 8'd0);
    chk("partial_cnt", W'(cnt), 8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register, the next generation of the lab's serial/parallel shift register. It supports hold, bidirectional shift, bidirectional rotate, parallel load and synchronous clear, with serial I/O at both ends. A saturating shift counter with a one-cycle done pulse lets a controlling FSM serialise or deserialise a full word without its own bit counter. It sits between datapath registers and serial links (SPI-like or bit-serial arithmetic) in the lab designs.

## Interface
- WIDTH, 8, register width in bits; legal range WIDTH >= 2.
- CW, $clog2(WIDTH+1), width of the shift counter; derived, never overridden.

- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  reset, synchronous and active-low.
- en  in  1  operation enable; when 0, all state holds regardless of mode.
- mode  in  3  operation select (see Operation).
- din  in  WIDTH  parallel load data.
- si_l  in  1  serial in, enters MSB on shift right.
- si_r  in  1  serial in, enters LSB on shift left.
- q  out  WIDTH  register contents, registered.
- so_r  out  1  last bit leaving the LSB end, registered.
- so_l  out  1  last bit leaving the MSB end, registered.
- cnt  out  CW  shifts/rotates since last load/clear, saturating at WIDTH.
- done  out  1  one-cycle pulse when cnt reaches WIDTH.

## Operation
- Priority per edge: rstn=0, then en=0 (hold), then mode.
- mode 000 HOLD: no change; done deasserts.
- mode 001 SHR: q <= {si_l, q[WIDTH-1:1]}; so_r <= q[0].
- mode 010 SHL: q <= {q[WIDTH-2:0], si_r}; so_l <= q[WIDTH-1].
- mode 011 ROR: q <= {q[0], q[WIDTH-1:1]}; so_r <= q[0].
- mode 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; so_l <= q[WIDTH-1].
- mode 101 LOAD: q <= din; cnt <= 0; so_r/so_l hold.
- mode 110 CLEAR: q <= 0; so_r <= 0; so_l <= 0; cnt <= 0.
- mode 111: identical to HOLD (reserved).
- so_r changes only on SHR/ROR/CLEAR/reset; so_l only on SHL/ROL/CLEAR/reset.
- Counter: each SHR/SHL/ROR/ROL with en=1 increments cnt if cnt < WIDTH, else holds at WIDTH. Direction does not matter; mixed directions all count.
- done: registered. It is 1 exactly in the cycle after the edge that moves cnt from WIDTH-1 to WIDTH, and 0 otherwise. It is not re-asserted while saturated, and it clears on any following edge, including en=0 edges.

## Timing
- Reset (rstn=0 at an edge): q=0, so_r=0, so_l=0, cnt=0, done=0; reset overrides en and mode.
- All outputs are registered; latency is one clock from inputs to q/so/cnt/done.
- No combinational path from inputs to outputs.
- Reset mid-sequence abandons the count; done is never produced for a partial word.
- LOAD and the shift that completes a word cannot coincide (single mode). LOAD on the cycle after done starts a new word cleanly.
- CLEAR or LOAD while cnt=WIDTH returns cnt to 0. A subsequent WIDTH shifts produce a new done.
- en=0 freezes cnt, q and so_*. done, if high, still falls on the next edge.

## Test plan
- Reset: drive random q via LOAD, assert rstn=0 for one edge with en=1, mode=SHR -> q=0x00, so_r=0, so_l=0, cnt=0, done=0.
- Serialise (WIDTH=8): LOAD din=0xA5, then 8 SHR edges with si_l=0 -> so_r sequence 1,0,1,0,0,1,0,1; q=0x00; cnt=8; done high for exactly one cycle after the 8th shift.
- Deserialise: CLEAR, then 8 SHL edges feeding si_r=1,1,0,1,0,0,1,0 -> q=0xD2, cnt=8, so_l=0 throughout.
- Rotate and saturation: LOAD 0x81, then 10 ROL edges -> q=0x03 after the first, 0x81 after 8, 0x06 after 10; cnt=8 after 8 and stays 8; done pulses once.
- Enable gating: LOAD 0x3C, 3 SHR edges, then en=0 for 4 edges with mode=SHR -> q=0x07 and cnt=3 held; re-enable for 5 SHR -> done pulses, cnt=8.
- Priority and reserved mode: mode=111 with en=1 holds q=0x5A. LOAD with cnt=8 -> cnt=0, so_r unchanged. CLEAR -> so_r=so_l=0.
